// File: rtl/branch_predictor_if.sv
// Fetch-lookup, EX-update and invalidate signals shared between the
// branch predictor and whoever drives it.
interface branch_predictor_if;

   logic [31:0] pc;
   logic [31:0] target_pc;
   logic        valid;
   logic        predicted_taken;
   logic        update;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic        inv_req;
   logic        inv_busy;

   modport master (
      output pc,
      output update,
      output update_pc,
      output update_target,
      output update_taken,
      output inv_req,
      input  target_pc,
      input  valid,
      input  predicted_taken,
      input  inv_busy
   );

   modport slave (
      input  pc,
      input  update,
      input  update_pc,
      input  update_target,
      input  update_taken,
      input  inv_req,
      output target_pc,
      output valid,
      output predicted_taken,
      output inv_busy
   );

endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookups are combinational; updates land on the clock edge and
// are not bypassed to a same-cycle lookup. An invalidate request starts a
// one-entry-per-cycle sweep, during which lookups miss and updates are dropped.
module branch_predictor #(
   parameter int ENTRIES  = 16,
   parameter int CNT_BITS = 2
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bus
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = 30 - IDX_BITS;

   localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
   localparam logic [CNT_BITS-1:0] CNT_WEAK   = CNT_BITS'(1 << (CNT_BITS - 1));
   localparam logic [IDX_BITS-1:0] SWEEP_LAST = IDX_BITS'(ENTRIES - 1);

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_BITS-1:0] sweep_q, sweep_d;
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
   logic [CNT_BITS-1:0] cnt_d    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];

   logic [IDX_BITS-1:0] look_idx;
   logic [TAG_BITS-1:0] look_tag;
   logic                look_hit;
   logic                look_taken;
   logic [31:0]         pc_plus4;
   logic [IDX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0] upd_tag;
   logic                upd_hit;

   assign look_idx = bus.pc[IDX_BITS+1:2];
   assign look_tag = bus.pc[31:IDX_BITS+2];
   assign upd_idx  = bus.update_pc[IDX_BITS+1:2];
   assign upd_tag  = bus.update_pc[31:IDX_BITS+2];
   assign pc_plus4 = bus.pc + 32'd4;

   // Zero-latency lookup from the registered table; a sweep masks every hit.
   always_comb begin
      look_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && (state_q == IDLE);
      look_taken = look_hit && cnt_q[look_idx][CNT_BITS-1];
      upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   end

   assign bus.valid           = look_hit;
   assign bus.predicted_taken = look_taken;
   assign bus.target_pc       = look_taken ? target_q[look_idx] : pc_plus4;
   assign bus.inv_busy        = (state_q == SWEEP);

   // Next table contents and sweep control: train or allocate on resolved
   // branches while idle, otherwise clear one entry per cycle.
   always_comb begin
      state_d  = state_q;
      sweep_d  = sweep_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      target_d = target_q;
      case (state_q)
         IDLE: begin
            if (bus.update) begin
               if (upd_hit) begin
                  if (bus.update_taken) begin
                     if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_ONE;
                     end
                     target_d[upd_idx] = bus.update_target;
                  end else if (cnt_q[upd_idx] != '0) begin
                     cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_ONE;
                  end
               end else if (bus.update_taken) begin
                  valid_d[upd_idx]  = 1'b1;
                  tag_d[upd_idx]    = upd_tag;
                  target_d[upd_idx] = bus.update_target;
                  cnt_d[upd_idx]    = CNT_WEAK;
               end
            end
            if (bus.inv_req) begin
               state_d = SWEEP;
               sweep_d = '0;
            end
         end
         SWEEP: begin
            valid_d[sweep_q] = 1'b0;
            cnt_d[sweep_q]   = CNT_WEAK;
            if (sweep_q == SWEEP_LAST) begin
               state_d = IDLE;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + IDX_BITS'(1);
            end
         end
         default: begin
            state_d = IDLE;
            sweep_d = '0;
         end
      endcase
   end

   // Control state, valid bits and counters; reset aborts any sweep at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sweep_q <= '0;
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_WEAK;
         end
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tag and target payload; only meaningful behind a set valid bit.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level reference model is
// checked against the DUT on every falling edge, and hand-computed literal
// expectations pin both the DUT and the model at key points.
module tb_branch_predictor;

   localparam int ENTRIES  = 16;
   localparam int CNT_BITS = 2;
   localparam int IDX_BITS = 4;
   localparam int CNT_TOP  = 3;
   localparam int CNT_WEAK = 2;

   logic clk;
   logic rst;

   branch_predictor_if bus ();

   branch_predictor #(
      .ENTRIES  (ENTRIES),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int compared;
   int mismatched;

   // Reference model state.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_cnt    [ENTRIES];
   int          m_busy_left;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Overall time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int idxOf(input logic [31:0] p);
      return int'((p >> 2) % ENTRIES);
   endfunction

   function automatic int unsigned tagOf(input logic [31:0] p);
      return int'(p >> (IDX_BITS + 2));
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_cnt[i]   = CNT_WEAK;
      end
      m_busy_left = 0;
   endfunction

   function automatic void modelLookup(input logic [31:0] p, output logic v, output logic t,
                                       output logic [31:0] tg);
      int i;
      i  = idxOf(p);
      v  = m_valid[i] && (m_tag[i] == tagOf(p)) && (m_busy_left == 0);
      t  = v && (m_cnt[i] >= CNT_WEAK);
      tg = t ? m_target[i] : p + 32'd4;
   endfunction

   function automatic void modelStep();
      int i;
      if (m_busy_left > 0) begin
         i = ENTRIES - m_busy_left;
         m_valid[i] = 1'b0;
         m_cnt[i]   = CNT_WEAK;
         m_busy_left--;
      end else begin
         if (bus.update) begin
            i = idxOf(bus.update_pc);
            if (m_valid[i] && m_tag[i] == tagOf(bus.update_pc)) begin
               if (bus.update_taken) begin
                  m_cnt[i]    = (m_cnt[i] < CNT_TOP) ? m_cnt[i] + 1 : CNT_TOP;
                  m_target[i] = bus.update_target;
               end else begin
                  m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
               end
            end else if (bus.update_taken) begin
               m_valid[i]  = 1'b1;
               m_tag[i]    = tagOf(bus.update_pc);
               m_target[i] = bus.update_target;
               m_cnt[i]    = CNT_WEAK;
            end
         end
         if (bus.inv_req) m_busy_left = ENTRIES;
      end
   endfunction

   // Model follows the same clock and asynchronous reset as the DUT.
   always @(posedge clk or negedge rst) begin
      if (!rst) modelReset();
      else modelStep();
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic        ev, et;
      logic [31:0] etg;
      modelLookup(bus.pc, ev, et, etg);
      compare("cyc.valid", 32'(bus.valid), 32'(ev));
      compare("cyc.predicted_taken", 32'(bus.predicted_taken), 32'(et));
      compare("cyc.target_pc", bus.target_pc, etg);
      compare("cyc.inv_busy", 32'(bus.inv_busy), 32'(m_busy_left > 0));
   end

   task automatic applyStimulus(input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                                input logic utaken, input logic inv, input logic [31:0] lpc);
      @(posedge clk);
      #1;
      bus.update        = upd;
      bus.update_pc     = upc;
      bus.update_target = utgt;
      bus.update_taken  = utaken;
      bus.inv_req       = inv;
      bus.pc            = lpc;
   endtask

   task automatic idle(input logic [31:0] lpc);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, lpc);
   endtask

   task automatic train(input logic [31:0] upc, input logic [31:0] utgt, input logic utaken);
      applyStimulus(1'b1, upc, utgt, utaken, 1'b0, upc);
      idle(upc);
   endtask

   // Literal expectation checked against the DUT and against the model.
   task automatic checkOutput(input string name, input logic v, input logic t,
                              input logic [31:0] tg, input logic busy);
      logic        mv, mt;
      logic [31:0] mtg;
      #1;
      compare({name, ".valid"}, 32'(bus.valid), 32'(v));
      compare({name, ".taken"}, 32'(bus.predicted_taken), 32'(t));
      compare({name, ".target"}, bus.target_pc, tg);
      compare({name, ".busy"}, 32'(bus.inv_busy), 32'(busy));
      modelLookup(bus.pc, mv, mt, mtg);
      compare({name, ".model_valid"}, 32'(mv), 32'(v));
      compare({name, ".model_taken"}, 32'(mt), 32'(t));
      compare({name, ".model_target"}, mtg, tg);
   endtask

   task automatic checkCnt(input string name, input logic [31:0] p, input int exp);
      compare(name, 32'(m_cnt[idxOf(p)]), 32'(exp));
   endtask

   initial begin
      int busy_cycles;
      compared   = 0;
      mismatched = 0;
      modelReset();
      bus.update        = 1'b0;
      bus.update_pc     = 32'h0;
      bus.update_target = 32'h0;
      bus.update_taken  = 1'b0;
      bus.inv_req       = 1'b0;
      bus.pc            = 32'h100;
      rst = 1'b1;
      #1 rst = 1'b0;
      checkOutput("reset", 1'b0, 1'b0, 32'h104, 1'b0);
      #21 rst = 1'b1;

      idle(32'h100);
      checkOutput("cold", 1'b0, 1'b0, 32'h104, 1'b0);

      applyStimulus(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h100);
      checkOutput("alloc_same_cycle", 1'b0, 1'b0, 32'h104, 1'b0);
      idle(32'h100);
      checkOutput("alloc_hit", 1'b1, 1'b1, 32'h200, 1'b0);
      checkCnt("cnt_alloc", 32'h100, 2);

      train(32'h100, 32'h200, 1'b0);
      checkOutput("nt1", 1'b1, 1'b0, 32'h104, 1'b0);
      checkCnt("cnt_nt1", 32'h100, 1);
      train(32'h100, 32'h200, 1'b0);
      checkOutput("nt2", 1'b1, 1'b0, 32'h104, 1'b0);
      checkCnt("cnt_nt2", 32'h100, 0);
      train(32'h100, 32'h200, 1'b0);
      checkCnt("cnt_nt3", 32'h100, 0);
      train(32'h100, 32'h200, 1'b1);
      checkOutput("t1", 1'b1, 1'b0, 32'h104, 1'b0);
      checkCnt("cnt_t1", 32'h100, 1);
      train(32'h100, 32'h200, 1'b1);
      checkOutput("t2", 1'b1, 1'b1, 32'h200, 1'b0);
      train(32'h100, 32'h200, 1'b1);
      checkCnt("cnt_t3", 32'h100, 3);
      train(32'h100, 32'h200, 1'b1);
      checkOutput("t4", 1'b1, 1'b1, 32'h200, 1'b0);
      checkCnt("cnt_t4", 32'h100, 3);
      train(32'h100, 32'h200, 1'b0);
      checkOutput("sat_top_nt", 1'b1, 1'b1, 32'h200, 1'b0);
      train(32'h100, 32'h280, 1'b1);
      checkOutput("new_target", 1'b1, 1'b1, 32'h280, 1'b0);

      idle(32'h140);
      checkOutput("alias_miss", 1'b0, 1'b0, 32'h144, 1'b0);
      applyStimulus(1'b1, 32'h140, 32'h300, 1'b0, 1'b0, 32'h100);
      idle(32'h100);
      checkOutput("alias_nt_keep", 1'b1, 1'b1, 32'h280, 1'b0);
      checkCnt("cnt_alias_nt", 32'h100, 3);
      train(32'h140, 32'h300, 1'b1);
      checkOutput("alias_alloc", 1'b1, 1'b1, 32'h300, 1'b0);
      checkCnt("cnt_alias_alloc", 32'h140, 2);
      idle(32'h100);
      checkOutput("alias_evicted", 1'b0, 1'b0, 32'h104, 1'b0);

      idle(32'hFFFF_FFFC);
      checkOutput("pc_wrap", 1'b0, 1'b0, 32'h0, 1'b0);

      train(32'h1004, 32'h400, 1'b1);
      checkOutput("fill_1004", 1'b1, 1'b1, 32'h400, 1'b0);
      train(32'h2008, 32'h500, 1'b1);
      checkOutput("fill_2008", 1'b1, 1'b1, 32'h500, 1'b0);

      applyStimulus(1'b1, 32'h30C, 32'h600, 1'b1, 1'b1, 32'h140);
      checkOutput("inv_accept", 1'b1, 1'b1, 32'h300, 1'b0);
      for (int i = 0; i < ENTRIES; i++) begin
         if (i == 3) applyStimulus(1'b1, 32'h82C, 32'h700, 1'b1, 1'b1, 32'h30C);
         else idle(32'h30C);
         checkOutput("sweep", 1'b0, 1'b0, 32'h310, 1'b1);
      end
      idle(32'h30C);
      checkOutput("post_30c", 1'b0, 1'b0, 32'h310, 1'b0);
      idle(32'h140);
      checkOutput("post_140", 1'b0, 1'b0, 32'h144, 1'b0);
      idle(32'h1004);
      checkOutput("post_1004", 1'b0, 1'b0, 32'h1008, 1'b0);
      idle(32'h2008);
      checkOutput("post_2008", 1'b0, 1'b0, 32'h200C, 1'b0);
      idle(32'h82C);
      checkOutput("post_82c", 1'b0, 1'b0, 32'h830, 1'b0);

      train(32'h1030, 32'h800, 1'b1);
      checkOutput("fill_1030", 1'b1, 1'b1, 32'h800, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1030);
      for (int i = 0; i < 5; i++) begin
         idle(32'h1030);
         checkOutput("sweep_pre_rst", 1'b0, 1'b0, 32'h1034, 1'b1);
      end
      @(posedge clk);
      #3 rst = 1'b0;
      checkOutput("rst_abort", 1'b0, 1'b0, 32'h1034, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      idle(32'h1030);
      checkOutput("rst_miss_1030", 1'b0, 1'b0, 32'h1034, 1'b0);
      checkCnt("cnt_rst", 32'h1030, 2);

      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1030);
      idle(32'h1030);
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.inv_busy) busy_cycles++;
         else break;
         @(posedge clk);
         #1;
      end
      compare("sweep_len", 32'(busy_cycles), 32'(ENTRIES));

      idle(32'h1030);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
